dram_arbiter: RTL

Two-port round-robin arbiter that shares the single backing DRAM between the instruction-side and data-side cache refill/write-through engines. Each requester issues one word-sized read or write, holds it until acknowledged, and gets a one-cycle ack with registered read data. The block sits between the cache controllers' memory ports and the DRAM model. It serialises accesses, latches request fields on grant, and guards against a hung DRAM with a watchdog.

---
 rtl/dram_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port round-robin arbiter sharing one DRAM between the
// icache (port 0) and dcache (port 1) memory engines.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req/we/addr/wdata{0,1}   requester command, held until ack
//   ack{0,1}                 one-cycle completion pulse
//   rdata{0,1}               registered read data, valid from ack onward
//   mem_req/we/addr/wdata    DRAM command, fields latched at grant
//   mem_ready, mem_rdata     DRAM completion strobe and read data
//   busy                     high whenever not IDLE
//   grant_id                 port currently or last served
//   err                      sticky watchdog-timeout flag
module dram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  grant_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  busy_q;
  logic                  err_q;

  // Round-robin winner: on a tie the port not served last time wins.
  logic win_c;
  logic any_req_c;

  always_comb begin
    win_c     = 1'b0;
    any_req_c = req0 | req1;
    if (req0 && req1) begin
      win_c = ~last_grant_q;
    end else if (req1) begin
      win_c = 1'b1;
    end
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_c) begin
            state_q      <= S_WAIT;
            grant_q      <= win_c;
            last_grant_q <= win_c;
            mem_we_q     <= win_c ? we1    : we0;
            mem_addr_q   <= win_c ? addr1  : addr0;
            mem_wdata_q  <= win_c ? wdata1 : wdata0;
            mem_req_q    <= 1'b1;
            busy_q       <= 1'b1;
            cnt_q        <= '0;
          end
        end

        S_WAIT: begin
          if (mem_ready) begin
            state_q   <= S_RESP;
            mem_req_q <= 1'b0;
            ack0_q    <= ~grant_q;
            ack1_q    <= grant_q;
            // Writes leave the requester's read data untouched.
            if (!mem_we_q) begin
              if (grant_q) rdata1_q <= mem_rdata;
              else         rdata0_q <= mem_rdata;
            end
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            // Watchdog: complete the access anyway so the requester is freed.
            state_q   <= S_RESP;
            mem_req_q <= 1'b0;
            ack0_q    <= ~grant_q;
            ack1_q    <= grant_q;
            err_q     <= 1'b1;
            if (!mem_we_q) begin
              if (grant_q) rdata1_q <= '0;
              else         rdata0_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign err       = err_q;

endmodule
